// File: rtl/cpu16_pkg.sv
// cpu16_pkg: shared definitions for the CPU16 execute stage.
//  - ALU operation codes as produced by the ALU control unit
//  - default datapath and shift-amount widths
//  - FSM state encoding for the execute stage
//  - is_shift(): true for the iterative shift operations
package cpu16_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_SLT = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SUB = 4'b1100;

  localparam int WIDTH_DEF = 16;
  localparam int SHW_DEF   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if: handshake bundle between the ALU control unit / consumer
// and the execute stage.
//  master (upstream + consumer side): drives flush, in_valid, alu_op, a_in,
//    b_in, out_ready; observes in_ready, out_valid, result, zero, ovf.
//  slave (execute stage): the mirror image.
interface alu_exec_stage_if
  import cpu16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;

  modport master (
    output flush, in_valid, alu_op, a_in, b_in, out_ready,
    input  in_ready, out_valid, result, zero, ovf
  );

  modport slave (
    input  flush, in_valid, alu_op, a_in, b_in, out_ready,
    output in_ready, out_valid, result, zero, ovf
  );
endinterface

// File: rtl/alu_comb_core.sv
// alu_comb_core: combinational single-cycle ALU operations.
//  op     in   4      operation code
//  a, b   in   WIDTH  operands (two's complement)
//  result out  WIDTH  AND/OR/XOR/ADD/SUB/SLT result, 0 for any other code
//  ovf    out  1      signed overflow for ADD/SUB, 0 otherwise
module alu_comb_core
  import cpu16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [3:0]              op,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic [WIDTH-1:0]        result,
  output logic                    ovf
);

  logic signed [WIDTH-1:0] sum;
  logic signed [WIDTH-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_ADD: begin
        result = sum;
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result = diff;
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, (a < b)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered execute stage of the CPU16 datapath.
//  clk, reset   single rising-edge clock, synchronous active-high reset
//  io (slave)   flush, in_valid/in_ready + alu_op/a_in/b_in on the input
//               side; out_valid/out_ready + result/zero/ovf on the output
// Single-cycle ops are written to the output register on the accept edge.
// SLL/SRA with a non-zero shift amount iterate one bit per cycle in a
// shift accumulator and write the output when the last bit is shifted.
// Only one operation is in flight: new work is accepted only in IDLE and
// only when the output register is empty or being drained this cycle.
module alu_exec_stage
  import cpu16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  alu_exec_stage_if.slave io
);

  state_t                  state_q, state_n;
  logic [SHW-1:0]          count_p0, count_n;
  logic signed [WIDTH-1:0] acc_p0, acc_n;
  logic                    sra_p0, sra_n;
  logic                    vld_p1, vld_n;
  logic [WIDTH-1:0]        result_p1, res_n;
  logic                    zero_p1, zero_n;
  logic                    ovf_p1, ovf_n;

  logic [WIDTH-1:0]        core_res;
  logic                    core_ovf;
  logic                    in_ready;
  logic                    accept;
  logic [SHW-1:0]          shamt;
  logic                    shift_req;
  logic signed [WIDTH-1:0] acc_step;
  logic                    write_out;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .op     (io.alu_op),
    .a      (io.a_in),
    .b      (io.b_in),
    .result (core_res),
    .ovf    (core_ovf)
  );

  assign shamt     = io.b_in[SHW-1:0];
  assign shift_req = is_shift(io.alu_op);
  assign in_ready  = (state_q == IDLE) && (!vld_p1 || io.out_ready) && !io.flush;
  assign accept    = io.in_valid && in_ready;
  assign acc_step  = sra_p0 ? (acc_p0 >>> 1) : (acc_p0 <<< 1);

  always_comb begin
    state_n   = state_q;
    count_n   = count_p0;
    acc_n     = acc_p0;
    sra_n     = sra_p0;
    vld_n     = vld_p1;
    res_n     = result_p1;
    zero_n    = zero_p1;
    ovf_n     = ovf_p1;
    write_out = 1'b0;

    if (io.flush) begin
      state_n = IDLE;
      count_n = '0;
      vld_n   = 1'b0;
    end else begin
      // A drain in this cycle frees the output; a write below may refill it.
      if (vld_p1 && io.out_ready) vld_n = 1'b0;

      case (state_q)
        IDLE: begin
          if (accept) begin
            if (shift_req && (shamt != '0)) begin
              acc_n   = io.a_in;
              count_n = shamt;
              sra_n   = (io.alu_op == ALU_SRA);
              state_n = SHIFT;
            end else begin
              // A zero-distance shift passes operand A straight through.
              write_out = 1'b1;
              res_n     = shift_req ? io.a_in : core_res;
              ovf_n     = shift_req ? 1'b0 : core_ovf;
            end
          end
        end
        SHIFT: begin
          acc_n   = acc_step;
          count_n = count_p0 - SHW'(1);
          if (count_p0 == SHW'(1)) begin
            write_out = 1'b1;
            res_n     = acc_step;
            ovf_n     = 1'b0;
            state_n   = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase

      if (write_out) begin
        vld_n  = 1'b1;
        zero_n = (res_n == '0);
      end
    end
  end

  // ---- stage boundary: shift accumulator (p0) and output register (p1) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_p0  <= '0;
      acc_p0    <= '0;
      sra_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      zero_p1   <= 1'b0;
      ovf_p1    <= 1'b0;
    end else begin
      state_q   <= state_n;
      count_p0  <= count_n;
      acc_p0    <= acc_n;
      sra_p0    <= sra_n;
      vld_p1    <= vld_n;
      result_p1 <= res_n;
      zero_p1   <= zero_n;
      ovf_p1    <= ovf_n;
    end
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = vld_p1;
  assign io.result    = result_p1;
  assign io.zero      = zero_p1;
  assign io.ovf       = ovf_p1;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: scoreboard bench for alu_exec_stage.
// The driver pushes the reference result and its due cycle on every accept;
// a monitor pops and compares whenever the stage presents an output.
module tb_alu_exec_stage;
  import cpu16_pkg::*;

  localparam int W = 16;

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        o;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_exec_stage_if #(.WIDTH(W)) io ();

  alu_exec_stage #(.WIDTH(W), .SHW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io.slave)
  );

  exp_t sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  bit   presented = 1'b0;
  bit   rand_bp   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   sa, sbv, s, n;
    sa  = $signed(a);
    sbv = $signed(b);
    n   = int'(b[3:0]);
    e.o = 1'b0;
    e.due = 0;
    case (op)
      ALU_AND: e.res = a & b;
      ALU_OR:  e.res = a | b;
      ALU_XOR: e.res = a ^ b;
      ALU_ADD: begin s = sa + sbv; e.res = s[15:0]; e.o = (s > 32767) || (s < -32768); end
      ALU_SUB: begin s = sa - sbv; e.res = s[15:0]; e.o = (s > 32767) || (s < -32768); end
      ALU_SLT: e.res = (sa < sbv) ? 16'd1 : 16'd0;
      ALU_SLL: begin s = int'(a) << n; e.res = s[15:0]; end
      ALU_SRA: begin s = sa >>> n; e.res = s[15:0]; end
      default: e.res = 16'd0;
    endcase
    e.z = (e.res == 16'd0);
    return e;
  endfunction

  function automatic int lat(input logic [3:0] op, input logic [15:0] b);
    return ((op == ALU_SLL) || (op == ALU_SRA)) ? int'(b[3:0]) : 0;
  endfunction

  task automatic clear_sb();
    sb.delete();
    presented = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    bit   done;
    e           = model(op, a, b);
    done        = 1'b0;
    io.in_valid = 1'b1;
    io.alu_op   = op;
    io.a_in     = a;
    io.b_in     = b;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge clk);
      if (io.in_ready) begin
        e.due = cyc + 1 + lat(op, b);
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout op=%0h in_ready never rose", op);
    end
    io.in_valid = 1'b0;
  endtask

  // Monitor: compare each presented output with the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && io.out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", {31'd0, io.out_valid}, 32'd0);
      end else begin
        if (!presented) begin
          chk("latency_cycle", cyc, sb[0].due);
          chk("result", {16'd0, io.result}, {16'd0, sb[0].res});
          chk("zero", {31'd0, io.zero}, {31'd0, sb[0].z});
          chk("ovf", {31'd0, io.ovf}, {31'd0, sb[0].o});
          presented = 1'b1;
        end else begin
          chk("held_result", {16'd0, io.result}, {16'd0, sb[0].res});
        end
        if (io.out_ready) begin
          void'(sb.pop_front());
          presented = 1'b0;
        end
      end
    end
  end

  // Random backpressure on the consumer side.
  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      io.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  ops [10];
    logic [15:0] a, b;
    ops = '{ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLL, ALU_SRA, 4'h5, 4'hF};

    reset        = 1'b1;
    io.flush     = 1'b0;
    io.in_valid  = 1'b0;
    io.alu_op    = 4'h0;
    io.a_in      = 16'h0;
    io.b_in      = 16'h0;
    io.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
    chk("rst_result", {16'd0, io.result}, 32'd0);
    chk("rst_zero", {31'd0, io.zero}, 32'd0);
    chk("rst_ovf", {31'd0, io.ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, io.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Directed single-cycle ops and boundaries
    send(ALU_ADD, 16'h7FFF, 16'h0001);
    send(ALU_SUB, 16'h0005, 16'h0005);
    send(ALU_SLT, 16'hFFFF, 16'h0001);
    send(ALU_SUB, 16'h8000, 16'h0001);
    send(4'h5, 16'h1234, 16'h5678);

    // SRA by 4: stage is busy for 4 cycles
    send(ALU_SRA, 16'h8000, 16'h0004);
    repeat (4) begin
      @(negedge clk);
      chk("shift_busy_in_ready", {31'd0, io.in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(ALU_SLL, 16'h0001, 16'h000F);
    send(ALU_SLL, 16'h1234, 16'h0000);

    // Backpressure, then drain and refill in the same cycle
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    io.out_ready = 1'b0;
    send(ALU_ADD, 16'h0002, 16'h0003);
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, io.out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, io.in_ready}, 32'd0);
      chk("bp_result", {16'd0, io.result}, 32'd5);
    end
    @(posedge clk);
    #1;
    io.out_ready = 1'b1;
    send(ALU_ADD, 16'h0010, 16'h0020);
    @(negedge clk);
    chk("refill_no_bubble", {31'd0, io.out_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Flush during SHIFT
    send(ALU_SLL, 16'h00FF, 16'h0008);
    @(posedge clk);
    #1;
    io.flush = 1'b1;
    clear_sb();
    @(negedge clk);
    chk("flush_in_ready_low", {31'd0, io.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    io.flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, io.out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, io.in_ready}, 32'd1);
    repeat (10) begin
      @(negedge clk);
      chk("flush_no_result", {31'd0, io.out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Reset mid-SHIFT
    send(ALU_SRA, 16'h1234, 16'h000A);
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_sb();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_shift_out_valid", {31'd0, io.out_valid}, 32'd0);
    chk("rst_shift_result", {16'd0, io.result}, 32'd0);
    chk("rst_shift_in_ready", {31'd0, io.in_ready}, 32'd1);
    repeat (12) begin
      @(negedge clk);
      chk("rst_shift_no_result", {31'd0, io.out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Reset while an output is held
    io.out_ready = 1'b0;
    send(ALU_ADD, 16'h1111, 16'h2222);
    @(negedge clk);
    chk("held_before_reset", {31'd0, io.out_valid}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_sb();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_held_out_valid", {31'd0, io.out_valid}, 32'd0);
    chk("rst_held_result", {16'd0, io.result}, 32'd0);
    chk("rst_held_zero", {31'd0, io.zero}, 32'd0);
    chk("rst_held_ovf", {31'd0, io.ovf}, 32'd0);
    chk("rst_held_in_ready", {31'd0, io.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    io.out_ready = 1'b1;

    // Randomized traffic with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 200; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 7))
        0: a = 16'h7FFF;
        1: a = 16'h8000;
        2: b = 16'hFFFF;
        3: b = a;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(ops[$urandom_range(0, 9)], a, b);
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #1;
    io.out_ready = 1'b1;
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
